// File: rtl/delay_ram_pkg.sv
// delay_ram_pkg: shared types, FSM states and pointer arithmetic for delay_ram_buffer.
// addr_t is sized from the package default and must be at least as wide as ADDRESS_WIDTH.
package delay_ram_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] sample_t;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_e;
    function automatic addr_t wrap_sub(addr_t a, addr_t b);
        return a - b;
    endfunction
endpackage

// File: rtl/delay_ram_buffer_dpram_core.sv
// dpram_core: one synchronous write port, NR synchronous read ports.
// The read outputs are registered and hold their value when re_i is low.
module dpram_core #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int NR = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we_i,
    input  logic [AW-1:0]          wa_i,
    input  logic [DW-1:0]          wd_i,
    input  logic                   re_i,
    input  logic [NR-1:0][AW-1:0]  ra_i,
    output logic [NR-1:0][DW-1:0]  rd_o
);
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [NR-1:0][DW-1:0] rd_q;
    always_ff @(posedge clk) begin
        if (we_i) mem[wa_i] <= wd_i;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_q <= '0;
        else if (re_i) begin
            for (int k = 0; k < NR; k++) rd_q[k] <= mem[ra_i[k]];
        end
    end
    assign rd_o = rd_q;
endmodule

// File: rtl/delay_ram_buffer.sv
// delay_ram_buffer: circular sample buffer giving NUM_TAPS independently delayed copies of din.
// Macro DELAY_RAM_BYPASS_EN: delay 0 forwards din; otherwise delay 0 is clamped to 1.
module delay_ram_buffer
    import delay_ram_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_TAPS      = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic                                  clr,
    input  logic [DATA_WIDTH-1:0]                 din,
    input  logic [NUM_TAPS-1:0][ADDRESS_WIDTH-1:0] delay,
    output logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]   dout,
    output logic [NUM_TAPS-1:0]                   dout_valid,
    output logic [ADDRESS_WIDTH:0]                fill_level,
    output logic                                  full
);
    localparam int DEPTH = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] FILL_MAX = (ADDRESS_WIDTH+1)'(DEPTH);
    state_e state_q;
    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH:0] fill_q, fill_d;
    logic [NUM_TAPS-1:0] valid_q, valid_d;
    logic [NUM_TAPS-1:0][ADDRESS_WIDTH-1:0] d_eff, rd_addr;
    logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] ram_rd;
    logic wr;
    assign wr = en && !clr;
    always_comb begin
        wr_ptr_d = clr ? '0 : en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        fill_d = clr ? '0 : (en && fill_q != FILL_MAX) ? fill_q + 1'b1 : fill_q;
        d_eff = '0;
        rd_addr = '0;
        valid_d = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
`ifdef DELAY_RAM_BYPASS_EN
            d_eff[k] = delay[k];
`else
            d_eff[k] = (delay[k] == '0) ? ADDRESS_WIDTH'(1) : delay[k];
`endif
            rd_addr[k] = ADDRESS_WIDTH'(wrap_sub(addr_t'(wr_ptr_q), addr_t'(d_eff[k])));
            valid_d[k] = wr && ({1'b0, d_eff[k]} <= fill_q);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            valid_q  <= '0;
        end else begin
            state_q  <= clr ? EMPTY : (fill_d == FILL_MAX) ? FULL : (fill_d != '0) ? FILLING : EMPTY;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            valid_q  <= valid_d;
        end
    end
    dpram_core #(.AW(ADDRESS_WIDTH), .DW(DATA_WIDTH), .NR(NUM_TAPS)) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we_i (wr),
        .wa_i (wr_ptr_q),
        .wd_i (din),
        .re_i (wr),
        .ra_i (rd_addr),
        .rd_o (ram_rd)
    );
`ifdef DELAY_RAM_BYPASS_EN
    // A zero-delay tap would read the address being written, so it takes a registered din instead.
    logic [NUM_TAPS-1:0] byp_q, byp_d;
    logic [DATA_WIDTH-1:0] din_q;
    always_comb begin
        byp_d = '0;
        for (int k = 0; k < NUM_TAPS; k++) byp_d[k] = (delay[k] == '0);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_q <= '0;
            din_q <= '0;
        end else if (wr) begin
            byp_q <= byp_d;
            din_q <= din;
        end
    end
    always_comb begin
        dout = ram_rd;
        for (int k = 0; k < NUM_TAPS; k++) dout[k] = byp_q[k] ? din_q : ram_rd[k];
    end
`else
    assign dout = ram_rd;
`endif
    assign dout_valid = valid_q;
    assign fill_level = fill_q;
    assign full       = (state_q == FULL);
endmodule

// File: tb/tb_delay_ram_buffer.sv
// tb_delay_ram_buffer: directed table-driven bench for delay_ram_buffer (depth 16, 8-bit, 2 taps).
module tb_delay_ram_buffer;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int NT = 2;
    typedef struct {
        logic en, clr;
        logic [7:0] din;
        logic [3:0] d0, d1;
        logic [1:0] v, chk;
        logic [7:0] o0, o1;
        logic [4:0] fill;
        logic full;
    } vec_t;
    logic clk = 0, rst = 1, en = 1, clr = 0;
    logic [DW-1:0] din = 8'h77;
    logic [NT-1:0][AW-1:0] delay = '0;
    logic [NT-1:0][DW-1:0] dout;
    logic [NT-1:0] dout_valid;
    logic [AW:0] fill_level;
    logic full;
    int n_chk = 0, n_fail = 0;
    vec_t tv [18];

    always #5 clk = ~clk;

    delay_ram_buffer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_TAPS(NT)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din), .delay(delay),
        .dout(dout), .dout_valid(dout_valid), .fill_level(fill_level), .full(full)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic c, input logic [7:0] d);
        en = e;
        clr = c;
        din = d;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic e, input logic c, input logic [7:0] d, input logic [3:0] a,
                                input logic [3:0] b, input logic [1:0] v, input logic [1:0] k,
                                input logic [7:0] o0, input logic [7:0] o1, input logic [4:0] f, input logic fu);
        vec_t r;
        r.en = e; r.clr = c; r.din = d; r.d0 = a; r.d1 = b; r.v = v; r.chk = k;
        r.o0 = o0; r.o1 = o1; r.fill = f; r.full = fu;
        return r;
    endfunction

    initial begin
        // ramp with delays {3,5}
        tv[0]  = mk(1, 0, 8'd1,  4'd3, 4'd5, 2'b00, 2'b00, 8'd0, 8'd0, 5'd1, 0);
        tv[1]  = mk(1, 0, 8'd2,  4'd3, 4'd5, 2'b00, 2'b00, 8'd0, 8'd0, 5'd2, 0);
        tv[2]  = mk(1, 0, 8'd3,  4'd3, 4'd5, 2'b00, 2'b00, 8'd0, 8'd0, 5'd3, 0);
        tv[3]  = mk(1, 0, 8'd4,  4'd3, 4'd5, 2'b01, 2'b01, 8'd1, 8'd0, 5'd4, 0);
        tv[4]  = mk(1, 0, 8'd5,  4'd3, 4'd5, 2'b01, 2'b01, 8'd2, 8'd0, 5'd5, 0);
        tv[5]  = mk(1, 0, 8'd6,  4'd3, 4'd5, 2'b11, 2'b11, 8'd3, 8'd1, 5'd6, 0);
        tv[6]  = mk(1, 0, 8'd7,  4'd3, 4'd5, 2'b11, 2'b11, 8'd4, 8'd2, 5'd7, 0);
        tv[7]  = mk(1, 0, 8'd8,  4'd3, 4'd5, 2'b11, 2'b11, 8'd5, 8'd3, 5'd8, 0);
        tv[8]  = mk(0, 0, 8'd99, 4'd3, 4'd5, 2'b00, 2'b11, 8'd5, 8'd3, 5'd8, 0);
        tv[9]  = mk(1, 0, 8'd9,  4'd3, 4'd5, 2'b11, 2'b11, 8'd6, 8'd4, 5'd9, 0);
        // gaps with delay 2
        tv[10] = mk(1, 0, 8'd10, 4'd2, 4'd2, 2'b11, 2'b11, 8'd8, 8'd8, 5'd10, 0);
        tv[11] = mk(0, 0, 8'd98, 4'd2, 4'd2, 2'b00, 2'b11, 8'd8, 8'd8, 5'd10, 0);
        tv[12] = mk(1, 0, 8'd11, 4'd2, 4'd2, 2'b11, 2'b11, 8'd9, 8'd9, 5'd11, 0);
        tv[13] = mk(0, 0, 8'd97, 4'd2, 4'd2, 2'b00, 2'b11, 8'd9, 8'd9, 5'd11, 0);
        // clr with en high, then refill
        tv[14] = mk(1, 1, 8'h55, 4'd2, 4'd2, 2'b00, 2'b11, 8'd9, 8'd9, 5'd0, 0);
        tv[15] = mk(1, 0, 8'h20, 4'd2, 4'd2, 2'b00, 2'b00, 8'd0, 8'd0, 5'd1, 0);
        tv[16] = mk(1, 0, 8'h21, 4'd2, 4'd2, 2'b00, 2'b00, 8'd0, 8'd0, 5'd2, 0);
        tv[17] = mk(1, 0, 8'h22, 4'd2, 4'd2, 2'b11, 2'b11, 8'h20, 8'h20, 5'd3, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset dout", dout, 0);
        chk("reset valid", dout_valid, 0);
        chk("reset fill", fill_level, 0);
        chk("reset full", full, 0);
        rst = 0;
        en = 0;

        for (int i = 0; i < 18; i++) begin
            delay[0] = tv[i].d0;
            delay[1] = tv[i].d1;
            step(tv[i].en, tv[i].clr, tv[i].din);
            chk($sformatf("v%0d valid", i), dout_valid, tv[i].v);
            chk($sformatf("v%0d fill", i), fill_level, tv[i].fill);
            chk($sformatf("v%0d full", i), full, tv[i].full);
            if (tv[i].chk[0]) chk($sformatf("v%0d dout0", i), dout[0], tv[i].o0);
            if (tv[i].chk[1]) chk($sformatf("v%0d dout1", i), dout[1], tv[i].o1);
        end

        // wrap: 40 samples, delay 15
        step(0, 1, 8'd0);
        delay[0] = 4'd15;
        delay[1] = 4'd15;
        for (int n = 1; n <= 40; n++) begin
            step(1, 0, 8'(n));
            if (n == 15) chk("wrap full before 16", full, 0);
            if (n >= 16) begin
                chk($sformatf("wrap fill n%0d", n), fill_level, 16);
                chk($sformatf("wrap full n%0d", n), full, 1);
                chk($sformatf("wrap valid n%0d", n), dout_valid, 2'b11);
                chk($sformatf("wrap dout0 n%0d", n), dout[0], n - 15);
            end
        end
        chk("wrap dout1 n40", dout[1], 25);

        // zero delay on tap 1
        delay[1] = 4'd0;
        step(1, 0, 8'hA5);
        chk("zero valid", dout_valid, 2'b11);
        chk("zero dout0", dout[0], 26);
`ifdef DELAY_RAM_BYPASS_EN
        chk("zero dout1 bypass", dout[1], 8'hA5);
`else
        chk("zero dout1 clamp", dout[1], 40);
`endif

        // asynchronous reset mid-stream
        #2 rst = 1;
        #1;
        chk("midrst dout", dout, 0);
        chk("midrst valid", dout_valid, 0);
        chk("midrst fill", fill_level, 0);
        chk("midrst full", full, 0);
        @(posedge clk);
        #1 rst = 0;
        delay[0] = 4'd1;
        delay[1] = 4'd1;
        step(1, 0, 8'h30);
        chk("post rst valid0", dout_valid, 0);
        chk("post rst fill", fill_level, 1);
        step(1, 0, 8'h31);
        chk("post rst valid1", dout_valid, 2'b11);
        chk("post rst dout0", dout[0], 8'h30);
        chk("post rst dout1", dout[1], 8'h30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
